// File: rtl/datapath_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : datapath_sequencer
// Purpose  : Multi-cycle control sequencer for the 16-bit windowed-register
//            datapath, with variable-latency data memory and a timeout watchdog.
//            Optional retired-instruction counter enabled by PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module datapath_sequencer #(
    parameter int MEM_TIMEOUT = 16
`ifdef PERF_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic             memAck,
    output logic             pcWrite,
    output logic             selImm,
    output logic             selMemOut,
    output logic             beq,
    output logic             jump,
    output logic             writeFR,
    output logic             writeDM,
    output logic             readDM,
    output logic             winUpdate,
    output logic             halted,
    output logic             memError
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] retired
`endif
);

    localparam int c_CNT_W = $clog2(MEM_TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [3:0] c_OP_ALU   = 4'b0000;
    localparam logic [3:0] c_OP_LOAD  = 4'b0001;
    localparam logic [3:0] c_OP_STORE = 4'b0010;
    localparam logic [3:0] c_OP_JUMP  = 4'b0100;
    localparam logic [3:0] c_OP_BEQ   = 4'b0101;
    localparam logic [3:0] c_OP_WIN   = 4'b1000;
    localparam logic [3:0] c_OP_IMM0  = 4'b1100;
    localparam logic [3:0] c_OP_IMM1  = 4'b1101;
    localparam logic [3:0] c_OP_IMM2  = 4'b1110;
    localparam logic [3:0] c_OP_HALT  = 4'b1111;

    typedef enum logic [2:0] {
        c_START    = 3'd0,
        c_EXEC     = 3'd1,
        c_MEM_WAIT = 3'd2,
        c_HALT     = 3'd3,
        c_ERROR    = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [c_CNT_W-1:0] r_waitCnt;
    logic [c_CNT_W-1:0] w_waitCntNext;
    logic               r_isLoad;
    logic               w_isLoadNext;
    logic               r_halted;
    logic               r_memError;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_START;
            r_waitCnt  <= '0;
            r_isLoad   <= 1'b0;
            r_halted   <= 1'b0;
            r_memError <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_waitCnt  <= w_waitCntNext;
            r_isLoad   <= w_isLoadNext;
            r_halted   <= r_halted | (r_state == c_HALT);
            r_memError <= r_memError | (r_state == c_ERROR);
        end
    end

    // Mealy decode; everything is forced low while rst is asserted so a reset
    // landing mid-transfer drops the memory strobe on that very cycle.
    always_comb begin
        w_nextState   = r_state;
        w_waitCntNext = r_waitCnt;
        w_isLoadNext  = r_isLoad;
        pcWrite       = 1'b0;
        selImm        = 1'b0;
        selMemOut     = 1'b0;
        beq           = 1'b0;
        jump          = 1'b0;
        writeFR       = 1'b0;
        writeDM       = 1'b0;
        readDM        = 1'b0;
        winUpdate     = 1'b0;
        if (!rst) begin
            case (r_state)
                c_START: begin
                    w_nextState = c_EXEC;
                end
                c_EXEC: begin
                    case (opcode)
                        c_OP_ALU: begin
                            writeFR = 1'b1;
                            pcWrite = 1'b1;
                        end
                        c_OP_LOAD: begin
                            readDM        = 1'b1;
                            w_isLoadNext  = 1'b1;
                            w_waitCntNext = '0;
                            w_nextState   = c_MEM_WAIT;
                        end
                        c_OP_STORE: begin
                            writeDM       = 1'b1;
                            w_isLoadNext  = 1'b0;
                            w_waitCntNext = '0;
                            w_nextState   = c_MEM_WAIT;
                        end
                        c_OP_JUMP: begin
                            jump    = 1'b1;
                            pcWrite = 1'b1;
                        end
                        c_OP_BEQ: begin
                            beq     = 1'b1;
                            pcWrite = 1'b1;
                        end
                        c_OP_WIN: begin
                            winUpdate = 1'b1;
                            pcWrite   = 1'b1;
                        end
                        c_OP_IMM0, c_OP_IMM1, c_OP_IMM2: begin
                            selImm  = 1'b1;
                            writeFR = 1'b1;
                            pcWrite = 1'b1;
                        end
                        c_OP_HALT: begin
                            w_nextState = c_HALT;
                        end
                        default: begin
                            pcWrite = 1'b1;
                        end
                    endcase
                end
                c_MEM_WAIT: begin
                    readDM  = r_isLoad;
                    writeDM = ~r_isLoad;
                    // An ack arriving on the final allowed cycle still retires.
                    if (memAck) begin
                        selMemOut     = r_isLoad;
                        writeFR       = r_isLoad;
                        pcWrite       = 1'b1;
                        w_waitCntNext = '0;
                        w_nextState   = c_EXEC;
                    end else if (r_waitCnt == c_CNT_LAST) begin
                        w_waitCntNext = '0;
                        w_nextState   = c_ERROR;
                    end else begin
                        w_waitCntNext = r_waitCnt + c_CNT_W'(1);
                    end
                end
                c_HALT: begin
                    w_nextState = c_HALT;
                end
                c_ERROR: begin
                    w_nextState = c_ERROR;
                end
                default: begin
                    w_nextState = c_START;
                end
            endcase
        end
    end

    assign halted   = r_halted & ~rst;
    assign memError = r_memError & ~rst;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] r_retired;

    // pcWrite is never raised in HALT/ERROR, so the count freezes there.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= '0;
        end else if (pcWrite) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign retired = rst ? '0 : r_retired;
`endif

endmodule
`default_nettype wire

// File: tb/tb_datapath_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_datapath_sequencer
// Purpose  : Randomized self-checking bench for datapath_sequencer against a
//            transaction-level model of instruction retirement.
// Revision : 1.0 - initial release
// ============================================================================
module tb_datapath_sequencer;

    localparam int c_TIMEOUT = 16;

    localparam logic [10:0] c_PC     = 11'h400;
    localparam logic [10:0] c_IMM    = 11'h200;
    localparam logic [10:0] c_MEMOUT = 11'h100;
    localparam logic [10:0] c_BEQ    = 11'h080;
    localparam logic [10:0] c_JMP    = 11'h040;
    localparam logic [10:0] c_FR     = 11'h020;
    localparam logic [10:0] c_WR     = 11'h010;
    localparam logic [10:0] c_RD     = 11'h008;
    localparam logic [10:0] c_WIN    = 11'h004;
    localparam logic [10:0] c_HALTED = 11'h002;
    localparam logic [10:0] c_MERR   = 11'h001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  opcode = 4'd0;
    logic        memAck = 1'b0;
    logic        pcWrite, selImm, selMemOut, beq, jump, writeFR;
    logic        writeDM, readDM, winUpdate, halted, memError;
    logic [10:0] outVec;
`ifdef PERF_CNT_EN
    logic [15:0] retired;
`endif
    logic [15:0] modelRetired = 16'd0;
    int          vecCount = 0;
    int          missCount = 0;

    always #5 clk = ~clk;

    datapath_sequencer #(
        .MEM_TIMEOUT(c_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .opcode(opcode),
        .memAck(memAck),
        .pcWrite(pcWrite),
        .selImm(selImm),
        .selMemOut(selMemOut),
        .beq(beq),
        .jump(jump),
        .writeFR(writeFR),
        .writeDM(writeDM),
        .readDM(readDM),
        .winUpdate(winUpdate),
        .halted(halted),
        .memError(memError)
`ifdef PERF_CNT_EN
        ,
        .retired(retired)
`endif
    );

    assign outVec = {pcWrite, selImm, selMemOut, beq, jump, writeFR,
                     writeDM, readDM, winUpdate, halted, memError};

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Single-cycle strobes of every instruction that retires straight out of EXEC.
    function automatic logic [10:0] execStrobes(input logic [3:0] op);
        case (op)
            4'b0000:                   return c_PC | c_FR;
            4'b0100:                   return c_PC | c_JMP;
            4'b0101:                   return c_PC | c_BEQ;
            4'b1000:                   return c_PC | c_WIN;
            4'b1100, 4'b1101, 4'b1110: return c_PC | c_IMM | c_FR;
            default:                   return c_PC;
        endcase
    endfunction

    task automatic cycleCheck(input logic [3:0] op, input logic ack,
                              input logic [10:0] exp, input string tag);
        @(negedge clk);
        opcode = op;
        memAck = ack;
        #1;
        checkVal(tag, 32'(outVec), 32'(exp));
`ifdef PERF_CNT_EN
        checkVal({tag, "_retired"}, 32'(retired), 32'(modelRetired));
`endif
        if ((exp & c_PC) != 11'd0)
            modelRetired = modelRetired + 16'd1;
    endtask

    task automatic doReset(input int n);
        modelRetired = 16'd0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst    = 1'b1;
            opcode = 4'($urandom);
            memAck = 1'($urandom);
            #1;
            checkVal("reset", 32'(outVec), 32'd0);
`ifdef PERF_CNT_EN
            checkVal("reset_retired", 32'(retired), 32'd0);
`endif
        end
        @(negedge clk);
        rst = 1'b0;
        opcode = 4'($urandom);
        memAck = 1'($urandom);
        #1;
        checkVal("start", 32'(outVec), 32'd0);
`ifdef PERF_CNT_EN
        checkVal("start_retired", 32'(retired), 32'd0);
`endif
    endtask

    // ackAt: MEM_WAIT cycle (1-based) carrying memAck, 0 = never.
    // rstAt: MEM_WAIT cycle on which reset is asserted, 0 = never.
    task automatic doMem(input logic isLoad, input int ackAt, input int rstAt);
        logic [3:0]  op;
        logic [10:0] dm;
        op = isLoad ? 4'b0001 : 4'b0010;
        dm = isLoad ? c_RD : c_WR;
        cycleCheck(op, 1'($urandom), dm, "mem_issue");
        for (int i = 1; i <= c_TIMEOUT; i++) begin
            if (i == rstAt) begin
                doReset(2);
                return;
            end
            if (i == ackAt) begin
                cycleCheck(op, 1'b1, dm | c_PC | (isLoad ? (c_MEMOUT | c_FR) : 11'd0), "mem_ack");
                return;
            end
            cycleCheck(op, 1'b0, dm, "mem_wait");
        end
        cycleCheck(4'($urandom), 1'($urandom), 11'd0, "err_entry");
        for (int i = 0; i < 3; i++)
            cycleCheck(4'($urandom), 1'($urandom), c_MERR, "err_sticky");
        doReset(1 + int'($urandom_range(0, 2)));
    endtask

    task automatic doHalt();
        cycleCheck(4'b1111, 1'($urandom), 11'd0, "halt_issue");
        cycleCheck(4'($urandom), 1'($urandom), 11'd0, "halt_entry");
        for (int i = 0; i < 3; i++)
            cycleCheck(4'($urandom), 1'($urandom), c_HALTED, "halt_sticky");
        doReset(1 + int'($urandom_range(0, 2)));
    endtask

    initial begin
        logic [3:0] op;
        int         sel;

        doReset(3);
        for (int i = 0; i < 3; i++)
            cycleCheck(4'b0000, 1'b0, c_PC | c_FR, "alu_reg");
        cycleCheck(4'b1101, 1'b0, c_PC | c_IMM | c_FR, "alu_imm");
        cycleCheck(4'b0100, 1'b1, c_PC | c_JMP, "jump");
        doMem(1'b1, 3, 0);
        doMem(1'b0, c_TIMEOUT, 0);
        cycleCheck(4'b0000, 1'b0, c_PC | c_FR, "after_late_ack");
        doMem(1'b0, 0, 0);
        doMem(1'b1, 0, 2);
        for (int i = 0; i < 5; i++)
            cycleCheck(4'b0000, 1'b0, c_PC | c_FR, "perf_alu");
        doHalt();

        for (int n = 0; n < 300; n++) begin
            op = 4'($urandom);
            if (op == 4'b0001 || op == 4'b0010) begin
                sel = int'($urandom_range(0, 19));
                if (sel == 0)
                    doMem(op == 4'b0001, 0, 0);
                else if (sel == 1)
                    doMem(op == 4'b0001, 0, int'($urandom_range(1, c_TIMEOUT)));
                else
                    doMem(op == 4'b0001, int'($urandom_range(1, c_TIMEOUT)), 0);
            end else if (op == 4'b1111) begin
                doHalt();
            end else begin
                cycleCheck(op, 1'($urandom), execStrobes(op), "exec");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
`default_nettype wire
